// File: rtl/logic_gate_pkg.sv
// Shared encodings for the pipelined logic-gate stage:
// function select codes and handshake buffer occupancy states.
package logic_gate_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/logic_gate_op.sv
// Combinational bitwise logic function with optional
// op-matched reduction to a single zero-extended bit.
module logic_gate_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             reduce,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] bw;
  logic             bit_r;

  always_comb begin
    bw    = '0;
    bit_r = 1'b0;
    unique case (op)
      OP_NAND: begin
        bw    = ~A | ~B;
        bit_r = ~&(A & B);
      end
      OP_AND: begin
        bw    = A & B;
        bit_r = &(A & B);
      end
      OP_OR: begin
        bw    = A | B;
        bit_r = |(A | B);
      end
      OP_NOR: begin
        bw    = ~(A | B);
        bit_r = ~|(A | B);
      end
      OP_XOR: begin
        bw    = A ^ B;
        bit_r = ^(A ^ B);
      end
      OP_XNOR: begin
        bw    = ~(A ^ B);
        bit_r = ~^(A ^ B);
      end
      OP_NOTA: begin
        bw    = ~A;
        bit_r = &(~A);
      end
      OP_PASSA: begin
        bw    = A;
        bit_r = &A;
      end
    endcase
    result = reduce ? WIDTH'(bit_r) : bw;
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered logic stage with valid/ready on both sides and a
// two-entry main/skid buffer so in_ready never depends on out_ready.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             reduce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             skid_to_main;

  logic_gate_op #(.WIDTH(WIDTH)) u_op (
    .A      (A),
    .B      (B),
    .op     (op),
    .reduce (reduce),
    .result (res)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign O         = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
      count  <= '0;
    end else begin
      if (load_main)         main_q <= res;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= res;
      if (out_xfer)          count  <= count + CNT_W'(1);
    end
  end

endmodule
